// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for the iterative fp16 divider.
// The slave side is the divider; the master side is whoever feeds it.
interface fp_div_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;

  modport master (
    output in_valid, opA, opB, out_ready,
    input  in_ready, out_valid, quotient
  );

  modport slave (
    input  in_valid, opA, opB, out_ready,
    output in_ready, out_valid, quotient
  );
endinterface

// File: rtl/fp_div_seq.sv
// Iterative fp16 divider (restoring, truncating, no denormals/NaN), one division in flight.
// BITS_PER_CYCLE quotient bits are resolved per DIV cycle; legal values divide 12.
module fp_div_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  fp_div_seq_if.slave  bus
);
  localparam int N = 12 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t             state, state_nx;
  logic               sign;
  logic [4:0]         ea, eb;
  logic [12:0]        rem, rem_nx;
  logic [10:0]        dsr;
  logic [11:0]        q, q_nx;
  logic [3:0]         cnt;
  logic [15:0]        quo;
  logic               accept, div_zero, dvd_zero, last;
  logic               sign_in;
  logic signed [6:0]  e_norm;
  logic [15:0]        norm_res;

  // Saturate to infinity on overflow, flush to signed zero on underflow.
  function automatic logic [15:0] pack_result(input logic s, input logic signed [6:0] e,
                                              input logic [9:0] m);
    if (e >= 7'sd31)     return {s, 5'h1F, 10'h000};
    else if (e <= 7'sd0) return {s, 15'h0000};
    else                 return {s, e[4:0], m};
  endfunction

  assign accept   = bus.in_valid && (state == IDLE);
  assign div_zero = (bus.opB[14:10] == 5'd0);
  assign dvd_zero = (bus.opA[14:10] == 5'd0);
  assign sign_in  = bus.opA[15] ^ bus.opB[15];
  assign last     = (cnt == 4'(N - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (div_zero || dvd_zero) ? DONE : DIV;
      DIV:     if (last) state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Restoring steps for one DIV cycle; quotient bits shift in MSB first.
  always_comb begin
    rem_nx = rem;
    q_nx   = q;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (rem_nx >= {2'b00, dsr}) begin
        rem_nx = rem_nx - {2'b00, dsr};
        q_nx   = {q_nx[10:0], 1'b1};
      end else begin
        q_nx   = {q_nx[10:0], 1'b0};
      end
      rem_nx = rem_nx << 1;
    end
  end

  // Quotient in [0.5,2): a clear q[11] means one extra normalising shift.
  always_comb begin
    e_norm = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd15;
    if (!q[11]) e_norm = e_norm - 7'sd1;
    norm_res = pack_result(sign, e_norm, q[11] ? q[10:1] : q[9:0]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sign <= 1'b0;
      ea   <= '0;
      eb   <= '0;
      rem  <= '0;
      dsr  <= '0;
      q    <= '0;
      cnt  <= '0;
      quo  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign <= sign_in;
          ea   <= bus.opA[14:10];
          eb   <= bus.opB[14:10];
          rem  <= {2'b00, 1'b1, bus.opA[9:0]};
          dsr  <= {1'b1, bus.opB[9:0]};
          q    <= '0;
          cnt  <= '0;
          if (div_zero)      quo <= {sign_in, 5'h1F, 10'h000};
          else if (dvd_zero) quo <= {sign_in, 15'h0000};
        end
        DIV: begin
          rem <= rem_nx;
          q   <= q_nx;
          cnt <= cnt + 4'd1;
        end
        NORM:    quo <= norm_res;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = quo;
endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: three instances (1, 3 and 12 bits per cycle) behind a selector,
// a vector table plus hand sequences for backpressure and mid-operation reset.
module tb_fp_div_seq;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        in_valid = 1'b0;
  logic [15:0] opA = '0, opB = '0;
  logic        out_ready = 1'b1;
  logic        in_ready_m, out_valid_m;
  logic [15:0] quotient_m;

  always #5 clock = ~clock;

  fp_div_seq_if b1 ();
  fp_div_seq_if b3 ();
  fp_div_seq_if b12 ();

  assign b1.in_valid  = in_valid && (sel == 2'd0);
  assign b3.in_valid  = in_valid && (sel == 2'd1);
  assign b12.in_valid = in_valid && (sel == 2'd2);
  assign b1.opA  = opA;  assign b1.opB  = opB;  assign b1.out_ready  = out_ready;
  assign b3.opA  = opA;  assign b3.opB  = opB;  assign b3.out_ready  = out_ready;
  assign b12.opA = opA;  assign b12.opB = opB;  assign b12.out_ready = out_ready;

  fp_div_seq #(.BITS_PER_CYCLE(1))  dut1  (.clock(clock), .reset_n(reset_n), .bus(b1));
  fp_div_seq #(.BITS_PER_CYCLE(3))  dut3  (.clock(clock), .reset_n(reset_n), .bus(b3));
  fp_div_seq #(.BITS_PER_CYCLE(12)) dut12 (.clock(clock), .reset_n(reset_n), .bus(b12));

  always_comb begin
    in_ready_m  = b1.in_ready;
    out_valid_m = b1.out_valid;
    quotient_m  = b1.quotient;
    if (sel == 2'd1) begin
      in_ready_m  = b3.in_ready;
      out_valid_m = b3.out_valid;
      quotient_m  = b3.quotient;
    end else if (sel == 2'd2) begin
      in_ready_m  = b12.in_ready;
      out_valid_m = b12.out_valid;
      quotient_m  = b12.quotient;
    end
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (sel=%0d t=%0t)", nm, act, req, sel, $time);
    end
  endtask

  // Scoreboard: every taken result is popped and compared.
  always @(negedge clock) begin
    if (reset_n && out_valid_m && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %h, required no output", quotient_m);
      end else begin
        check("quotient", {16'h0, quotient_m}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input int lat);
    int t = 0;
    int n = 0;
    @(negedge clock);
    while (!in_ready_m && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("in_ready_before_accept", {31'h0, in_ready_m}, 32'h1);
    in_valid = 1'b1;
    opA = a;
    opB = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    opA = '0;
    opB = '0;
    sb.push_back(exp);
    while (!out_valid_m && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
  endtask

  task automatic finish_op(input logic [15:0] exp);
    int t = 0;
    while (out_valid_m && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("out_valid_drop", {31'h0, out_valid_m}, 32'h0);
    check("quotient_hold", {16'h0, quotient_m}, {16'h0, exp});
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[$];

  initial begin
    vt.push_back('{2'd0, 16'h4600, 16'h4000, 16'h4200, 13});
    vt.push_back('{2'd0, 16'h3C00, 16'h4200, 16'h3555, 13});
    vt.push_back('{2'd0, 16'hBC00, 16'h4200, 16'hB555, 13});
    vt.push_back('{2'd0, 16'h3C00, 16'h0000, 16'h7C00, 0});
    vt.push_back('{2'd0, 16'h8000, 16'h4000, 16'h8000, 0});
    vt.push_back('{2'd0, 16'h0000, 16'h0000, 16'h7C00, 0});
    vt.push_back('{2'd0, 16'hBC00, 16'h8000, 16'h7C00, 0});
    vt.push_back('{2'd0, 16'h7800, 16'h0400, 16'h7C00, 13});
    vt.push_back('{2'd0, 16'h0400, 16'h7800, 16'h0000, 13});
    vt.push_back('{2'd0, 16'h4000, 16'h3C00, 16'h4000, 13});
    vt.push_back('{2'd0, 16'hC500, 16'h4000, 16'hC100, 13});
    vt.push_back('{2'd0, 16'h3C00, 16'h4900, 16'h2E66, 13});
    vt.push_back('{2'd0, 16'h7BFF, 16'h3C00, 16'h7BFF, 13});
    vt.push_back('{2'd0, 16'h0400, 16'h3C00, 16'h0400, 13});
    vt.push_back('{2'd0, 16'h0400, 16'h3E00, 16'h0000, 13});
    vt.push_back('{2'd0, 16'h7C00, 16'h3C00, 16'h7C00, 13});
    vt.push_back('{2'd0, 16'h3C00, 16'h7C00, 16'h0000, 13});
    vt.push_back('{2'd1, 16'h3C00, 16'h4200, 16'h3555, 5});
    vt.push_back('{2'd1, 16'hBC00, 16'h4200, 16'hB555, 5});
    vt.push_back('{2'd2, 16'h3C00, 16'h4200, 16'h3555, 2});
    vt.push_back('{2'd2, 16'h4600, 16'h4000, 16'h4200, 2});

    repeat (3) @(negedge clock);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("reset_in_ready", {31'h0, in_ready_m}, 32'h1);
      check("reset_out_valid", {31'h0, out_valid_m}, 32'h0);
      check("reset_quotient", {16'h0, quotient_m}, 32'h0);
    end
    sel = 2'd0;
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clock);
      sel = vt[i].sel;
      start_op(vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);
      finish_op(vt[i].exp);
    end

    // Backpressure: result must hold and new operands must be ignored.
    @(negedge clock);
    sel = 2'd0;
    out_ready = 1'b0;
    start_op(16'h3C00, 16'h4200, 16'h3555, 13);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      in_valid = 1'b1;
      opA = 16'h4600;
      opB = 16'h4000;
      check("bp_out_valid", {31'h0, out_valid_m}, 32'h1);
      check("bp_quotient", {16'h0, quotient_m}, 32'h3555);
      check("bp_in_ready", {31'h0, in_ready_m}, 32'h0);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_op(16'h3555);
    check("bp_in_ready_after", {31'h0, in_ready_m}, 32'h1);
    repeat (20) @(negedge clock);
    start_op(16'h4000, 16'h3C00, 16'h4000, 13);
    finish_op(16'h4000);

    // Reset in the middle of DIV: nothing may be emitted.
    @(negedge clock);
    in_valid = 1'b1;
    opA = 16'h4600;
    opB = 16'h4000;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("pre_reset_busy", {31'h0, in_ready_m}, 32'h0);
    reset_n = 1'b0;
    #1;
    check("abort_in_ready", {31'h0, in_ready_m}, 32'h1);
    check("abort_out_valid", {31'h0, out_valid_m}, 32'h0);
    check("abort_quotient", {16'h0, quotient_m}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    start_op(16'h4600, 16'h4000, 16'h4200, 13);
    finish_op(16'h4200);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
